// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: UART transmitter (start, DBIT data LSB-first, optional parity, stop) paced by a 16x oversampling tick
module uart_tx_8n1 #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            busy,
    output logic            tx_done_tick
);
    localparam int SW = SB_TICK > 16 ? 5 : 4;
    localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            p;

    // Frame FSM; tx is loaded with the level of the state being entered so it switches on the same edge as the state.
    // tx_done_tick is raised while still in STOP and the return to IDLE follows one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            p            <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: if (tx_start) begin
                    state <= START;
                    b     <= din;
                    s     <= '0;
                    p     <= (PARITY == 2);
                    tx    <= 1'b0;
                    busy  <= 1'b1;
                end
                START: if (s_tick) begin
                    if (s == S_LAST) begin
                        s     <= '0;
                        n     <= '0;
                        state <= DATA;
                        tx    <= b[0];
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                DATA: if (s_tick) begin
                    if (s == S_LAST) begin
                        s <= '0;
                        b <= b >> 1;
                        p <= p ^ b[0];
                        if (n == N_LAST) begin
                            state <= PARITY != 0 ? PAR : STOP;
                            tx    <= PARITY != 0 ? p ^ b[0] : 1'b1;
                        end else begin
                            n  <= n + 1'b1;
                            tx <= b[1];
                        end
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                PAR: if (s_tick) begin
                    if (s == S_LAST) begin
                        s     <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                STOP: if (tx_done_tick) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (s_tick) begin
                    if (s == S_STOP) begin
                        s            <= '0;
                        tx_done_tick <= 1'b1;
                    end else begin
                        s <= s + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: directed frame vectors plus hand sequences for done-cycle start, async reset and tick stall
module tb_uart_tx_8n1;
    typedef struct {
        int          id;
        logic [7:0]  d;
        logic [10:0] expv;
        int          nb;
        int          ticks;
        int          busy_cyc;
        bit          harass;
        int          stall_at;
    } vec_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       s_tick  = 1'b0;
    logic       tick_en = 1'b1;
    logic [3:0] start_a = '0;
    logic [3:0] tx_a, busy_a, done_a;
    logic [7:0] din_a [4];
    int         tc    = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       vt [6];
    vec_t       hv;

    uart_tx_8n1 #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut0 (.clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start_a[0]), .din(din_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .tx_done_tick(done_a[0]));
    uart_tx_8n1 #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut1 (.clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start_a[1]), .din(din_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .tx_done_tick(done_a[1]));
    uart_tx_8n1 #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut2 (.clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start_a[2]), .din(din_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .tx_done_tick(done_a[2]));
    uart_tx_8n1 #(.DBIT(8), .SB_TICK(32), .PARITY(0)) dut3 (.clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(start_a[3]), .din(din_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .tx_done_tick(done_a[3]));

    always #5 clk = ~clk;

    // One s_tick every 4 clk, updated on the falling edge; forced low while tick_en is low
    always @(negedge clk) begin
        if (tick_en) begin
            tc     = (tc + 1) % 4;
            s_tick = (tc == 0);
        end else begin
            s_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse tx_start for one edge; with align the accepting edge directly follows an s_tick edge
    task automatic accept(input int id, input logic [7:0] d, input bit align);
        int guard = 0;
        if (align) begin
            do begin
                step();
                guard++;
            end while (!s_tick && guard < 20);
        end
        start_a[id] = 1'b1;
        din_a[id]   = d;
        step();
        start_a[id] = 1'b0;
        din_a[id]   = ~d;
    endtask

    // Called on the sample right after the accepting edge; follows the frame by counting s_ticks
    task automatic frame(input vec_t v);
        int t = 0, idx = 0, bad_tx = 0, first = -1, nbusy = 0, post = 0;
        int ndone = 0, done_t = -1, done_c = -1, stall_bad = 0;
        bit stalled = 1'b0;
        for (int c = 0; c < 3000 && post < 4; c++) begin
            if (c > 0) begin
                step();
                start_a[v.id] = 1'b0;
                if (s_tick) t++;
            end
            idx = (t / 16 > v.nb - 1) ? v.nb - 1 : t / 16;
            if (tx_a[v.id] !== v.expv[idx]) begin
                if (bad_tx == 0) first = c;
                bad_tx++;
            end
            if (busy_a[v.id] === 1'b1) nbusy++;
            else if (nbusy > 0) post++;
            if (done_a[v.id] === 1'b1) begin
                ndone++;
                done_t = t;
                done_c = c;
            end
            if (v.harass && busy_a[v.id] === 1'b1 && c % 100 == 50 && c < 600) begin
                start_a[v.id] = 1'b1;
                din_a[v.id]   = 8'(c * 7);
            end
            if (v.stall_at != 0 && !stalled && t == v.stall_at) begin
                stalled = 1'b1;
                tick_en = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    step();
                    if (tx_a[v.id] !== 1'b1 || busy_a[v.id] !== 1'b1 || done_a[v.id] !== 1'b0) stall_bad++;
                end
                tick_en = 1'b1;
            end
        end
        check($sformatf("tx_wave id=%0d din=%h first_bad_cycle=%0d", v.id, v.d, first), bad_tx, 0);
        check("frame_end", post, 4);
        check("done_pulses", ndone, 1);
        check("ticks_at_done", done_t, v.ticks);
        if (v.busy_cyc != 0) begin
            check("busy_cycles", nbusy, v.busy_cyc);
            check("done_cycle", done_c, v.busy_cyc - 1);
        end
        if (v.stall_at != 0) begin
            check("stall_reached", stalled, 1);
            check("stall_hold", stall_bad, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din_a[i] = '0;
        vt[0] = '{0, 8'hA5, 11'b0_1_1010_0101_0, 10, 160, 640, 1'b0, 0};
        vt[1] = '{0, 8'h3C, 11'b0_1_0011_1100_0, 10, 160, 640, 1'b1, 0};
        vt[2] = '{1, 8'h07, 11'b1_1_0000_0111_0, 11, 176, 704, 1'b0, 0};
        vt[3] = '{2, 8'h07, 11'b1_0_0000_0111_0, 11, 176, 704, 1'b0, 0};
        vt[4] = '{3, 8'hC3, 11'b0_1_1100_0011_0, 10, 176, 704, 1'b0, 0};
        vt[5] = '{3, 8'h5A, 11'b0_1_0101_1010_0, 10, 176, 0, 1'b0, 152};

        #1 rst_n = 1'b0;
        #2;
        check("reset_tx", tx_a, 4'hF);
        check("reset_busy", busy_a, 4'h0);
        check("reset_done", done_a, 4'h0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();
        check("idle_tx", tx_a, 4'hF);
        check("idle_busy", busy_a, 4'h0);

        for (int i = 0; i < 6; i++) begin
            accept(vt[i].id, vt[i].d, 1'b1);
            frame(vt[i]);
        end

        // tx_start on the done cycle is dropped, the next cycle it is taken
        accept(0, 8'h81, 1'b1);
        begin
            int g = 0;
            while (done_a[0] !== 1'b1 && g < 1000) begin
                step();
                g++;
            end
            check("done_seen", done_a[0], 1);
        end
        start_a[0] = 1'b1;
        din_a[0]   = 8'hFF;
        step();
        check("start_on_done_busy", busy_a[0], 0);
        check("start_on_done_tx", tx_a[0], 1);
        din_a[0] = 8'h55;
        step();
        start_a[0] = 1'b0;
        din_a[0]   = 8'h00;
        check("start_after_done_busy", busy_a[0], 1);
        check("start_after_done_tx", tx_a[0], 0);
        hv = '{0, 8'h55, 11'b0_1_0101_0101_0, 10, 160, 0, 1'b0, 0};
        frame(hv);

        // asynchronous reset in the middle of data bit 3
        repeat (5) step();
        accept(0, 8'hA5, 1'b1);
        begin
            int t = 0, g = 0;
            while (t < 72 && g < 400) begin
                step();
                if (s_tick) t++;
                g++;
            end
            check("reach_bit3", t, 72);
        end
        check("bit3_tx", tx_a[0], 0);
        check("bit3_busy", busy_a[0], 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx_a[0], 1);
        check("async_rst_busy", busy_a[0], 0);
        check("async_rst_done", done_a[0], 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_idle_tx", tx_a[0], 1);
        hv = '{0, 8'h3C, 11'b0_1_0011_1100_0, 10, 160, 640, 1'b0, 0};
        accept(0, 8'h3C, 1'b1);
        frame(hv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Serial UART transmitter; the transmit-side counterpart to the block's existing UART receive path.
- Shares the same 16x-oversampling `s_tick` from the baud-rate counter.
- Serialises one parallel word per request: start bit, DBIT data bits LSB-first, optional parity, stop period.
- Reports busy and completion to the host-side logic that feeds the CORDIC result out over UART.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, stop period length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_tick  input  1  one-clk-wide oversampling pulse, 16 per bit period.
- tx_start  input  1  one-clk request to send `din`; honoured only in IDLE.
- din  input  DBIT  parallel data word, sampled in the cycle tx_start is accepted.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high in every state except IDLE.
- tx_done_tick  output  1  one-clk pulse at end of stop period.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, tx=1, busy=0, tx_done_tick=0, tick counter=0, bit counter=0, shift register=0. Takes effect immediately, including mid-frame; line returns to 1 without finishing the frame.
- States: IDLE, START, DATA, PARITY (only when PARITY!=0), STOP.
- Internal registers: 4-bit tick counter s, bit counter n (ceil(log2(DBIT)) bits), shift register b[DBIT-1:0], parity accumulator p.
- IDLE:
  - tx=1.
  - On tx_start=1: b<=din, s<=0, p<=0 (even) or 1 (odd), go to START. tx goes 0 on the next clk edge (1-cycle latency from acceptance).
- START:
  - tx=0.
  - On each s_tick: if s==15, then s<=0, n<=0, go to DATA; else s<=s+1.
- DATA:
  - tx=b[0].
  - On s_tick with s==15: s<=0, b<=b>>1, p<=p^b[0].
    - If n==DBIT-1, go to PARITY (or STOP when PARITY=0).
    - Else n<=n+1.
  - On other s_tick: s<=s+1.
- PARITY:
  - tx=p.
  - After 16 ticks (s==15 on s_tick), s<=0, go to STOP.
- STOP:
  - tx=1.
  - On s_tick with s==SB_TICK-1: s<=0, assert tx_done_tick for exactly one clk, go to IDLE.
  - Tick counter width: 5 bits when SB_TICK>16.
- Ticks: s advances only on clk edges where s_tick=1; with s_tick held 0 the FSM and tx hold indefinitely.
- Frame length: (1+DBIT+(PARITY?1:0))*16 + SB_TICK s_ticks.
- tx_start while busy=1 is ignored; no queuing.
- tx_start in the same cycle as tx_done_tick is ignored, since the state is still STOP. The earliest new acceptance is the cycle after tx_done_tick.
- `din` changes after acceptance do not affect the frame in flight.
- `busy` is high from the clk edge after acceptance through the tx_done_tick cycle, and low the cycle after.
- `tx` comes directly from a flop; no combinational path from inputs to tx.

Test Plan:
- Default params, s_tick every 4 clk, din=8'hA5, tx_start pulse:
  - tx reads 0, then 1,0,1,0,0,1,0,1, then 1; each bit 64 clk.
  - tx_done_tick is one pulse 640 clk after acceptance.
  - busy high for exactly 640 cycles.
- PARITY=1, din=8'h07 -> parity bit 1. PARITY=2, same data -> parity bit 0. Frame is 11 bit periods plus stop.
- tx_start pulsed every 100 clk during a frame with varying din -> only the first word transmitted; no glitch on tx; no extra tx_done_tick.
- tx_start asserted on the tx_done_tick cycle -> ignored. tx_start the following cycle -> accepted, START begins one clk later.
- rst_n pulsed low during DATA bit 3 (tx=0) -> tx=1 and busy=0 asynchronously before the next clk edge. A subsequent tx_start of 8'h3C sends a clean full frame.
- SB_TICK=32, s_tick held 0 for 200 clk in mid-STOP -> tx stays 1, no tx_done_tick. Stop period totals 32 ticks once ticks resume.
